// File: rtl/mmc3_scanline_irq_pkg.sv
// Shared defaults and CPU register map for the MMC3 scanline IRQ block.
// Build option: MMC3_IRQ_OLD_REV_EN selects MMC3A/NEC IRQ behaviour in the top.
package mmc3_scanline_irq_pkg;

    localparam int unsigned CNT_W_DEF       = 8;
    localparam int unsigned A12_LOW_MIN_DEF = 3;

    // IRQ registers live at $C000-$FFFF; A13 picks C/E, A0 picks even/odd
    localparam logic [15:0] ADDR_IRQ_LATCH   = 16'hC000;
    localparam logic [15:0] ADDR_IRQ_RELOAD  = 16'hC001;
    localparam logic [15:0] ADDR_IRQ_DISABLE = 16'hE000;
    localparam logic [15:0] ADDR_IRQ_ENABLE  = 16'hE001;

    typedef enum logic [1:0] {
        IRQ_REG_LATCH   = 2'd0,
        IRQ_REG_RELOAD  = 2'd1,
        IRQ_REG_DISABLE = 2'd2,
        IRQ_REG_ENABLE  = 2'd3
    } irq_reg_e;

    typedef struct packed {
        logic latch_we;
        logic reload_we;
        logic disable_we;
        logic enable_we;
    } irq_strobes_t;

    function automatic irq_reg_e irq_reg_decode(input logic [15:0] addr);
        return irq_reg_e'({addr[13], addr[0]});
    endfunction

    // Helper for the mapper decoder: CPU write to strobe bundle
    function automatic irq_strobes_t irq_strobes_decode(input logic [15:0] addr,
                                                        input logic        we);
        irq_strobes_t s;
        s = '0;
        if (we && (addr[15:14] == 2'b11)) begin
            unique case (irq_reg_decode(addr))
                IRQ_REG_LATCH:   s.latch_we   = 1'b1;
                IRQ_REG_RELOAD:  s.reload_we  = 1'b1;
                IRQ_REG_DISABLE: s.disable_we = 1'b1;
                IRQ_REG_ENABLE:  s.enable_we  = 1'b1;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/mmc3_scanline_irq_a12_rise_filter.sv
// PPU A12 synchroniser and low-time filter; emits a one-cycle clk_evt per
// qualifying rising edge, three m2 edges after the raw rise.
module mmc3_scanline_irq_a12_rise_filter #(
    parameter int unsigned A12_LOW_MIN = 3
) (
    input  logic i_m2,
    input  logic i_reset,
    input  logic i_ppu_a12,
    output logic o_clk_evt
);

    localparam int unsigned LOW_W = $clog2(A12_LOW_MIN + 1);

    logic             r_a12_meta;
    logic             r_a12_s;
    logic [LOW_W-1:0] r_low_cnt;
    logic             r_clk_evt;

    // A rise qualifies only when the preceding low period reached the minimum;
    // low_cnt > 0 already implies the previous sample was low.
    always_ff @(posedge i_m2 or posedge i_reset) begin
        if (i_reset) begin
            r_a12_meta <= 1'b0;
            r_a12_s    <= 1'b0;
            r_low_cnt  <= '0;
            r_clk_evt  <= 1'b0;
        end else begin
            r_a12_meta <= i_ppu_a12;
            r_a12_s    <= r_a12_meta;
            r_clk_evt  <= r_a12_s && (r_low_cnt == LOW_W'(A12_LOW_MIN));
            if (r_a12_s) begin
                r_low_cnt <= '0;
            end else if (r_low_cnt != LOW_W'(A12_LOW_MIN)) begin
                r_low_cnt <= r_low_cnt + LOW_W'(1);
            end
        end
    end

    assign o_clk_evt = r_clk_evt;

endmodule

// File: rtl/mmc3_scanline_irq.sv
// MMC3 scanline IRQ: counter reload/decrement on filtered A12 rises, IRQ flag.
// Build option: MMC3_IRQ_OLD_REV_EN selects MMC3A/NEC IRQ rules (default MMC3B/C).
module mmc3_scanline_irq
    import mmc3_scanline_irq_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned A12_LOW_MIN = A12_LOW_MIN_DEF
) (
    input  logic             m2,
    input  logic             reset,
    input  logic             ppu_a12,
    input  logic             irq_latch_we,
    input  logic             irq_reload_we,
    input  logic             irq_disable_we,
    input  logic             irq_enable_we,
    input  logic [CNT_W-1:0] cpu_data,
    output logic             irq_pending,
    output logic [CNT_W-1:0] irq_counter
);

    irq_strobes_t     w_stb;
    logic             w_clk_evt;
    logic             w_reload;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_irq_arm;

    logic [CNT_W-1:0] r_latch;
    logic [CNT_W-1:0] r_counter;
    logic             r_reload_flag;
    logic             r_enabled;
    logic             r_pending;

    assign w_stb = '{latch_we:   irq_latch_we,
                     reload_we:  irq_reload_we,
                     disable_we: irq_disable_we,
                     enable_we:  irq_enable_we};

    mmc3_scanline_irq_a12_rise_filter #(
        .A12_LOW_MIN (A12_LOW_MIN)
    ) u_a12_rise_filter (
        .i_m2      (m2),
        .i_reset   (reset),
        .i_ppu_a12 (ppu_a12),
        .o_clk_evt (w_clk_evt)
    );

    // Counter value a clk_evt would produce; a same-cycle reload strobe uses the old latch
    always_comb begin
        w_reload   = 1'b0;
        w_cnt_next = r_counter;
        w_irq_arm  = 1'b0;
        w_reload   = r_reload_flag || w_stb.reload_we || (r_counter == '0);
        w_cnt_next = w_reload ? r_latch : (r_counter - CNT_W'(1));
`ifdef MMC3_IRQ_OLD_REV_EN
        w_irq_arm  = r_enabled && (w_cnt_next == '0) &&
                     ((r_counter != '0) || r_reload_flag || w_stb.reload_we);
`else
        w_irq_arm  = r_enabled && (w_cnt_next == '0);
`endif
    end

    always_ff @(posedge m2 or posedge reset) begin
        if (reset) begin
            r_latch       <= '0;
            r_counter     <= '0;
            r_reload_flag <= 1'b0;
            r_enabled     <= 1'b0;
            r_pending     <= 1'b0;
        end else begin
            if (w_stb.latch_we) begin
                r_latch <= cpu_data;
            end

            if (w_clk_evt) begin
                r_counter     <= w_cnt_next;
                r_reload_flag <= 1'b0;
            end else if (w_stb.reload_we) begin
                r_counter     <= '0;
                r_reload_flag <= 1'b1;
            end

            if (w_stb.disable_we) begin
                r_enabled <= 1'b0;
            end else if (w_stb.enable_we) begin
                r_enabled <= 1'b1;
            end

            // Acknowledge beats a coincident IRQ set
            if (w_stb.disable_we) begin
                r_pending <= 1'b0;
            end else if (w_clk_evt && w_irq_arm) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign irq_pending = r_pending;
    assign irq_counter = r_counter;

endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// Directed bench for mmc3_scanline_irq; expectations follow MMC3_IRQ_OLD_REV_EN when defined.
module tb_mmc3_scanline_irq;

    logic       m2 = 1'b0;
    logic       reset;
    logic       ppu_a12;
    logic       irq_latch_we;
    logic       irq_reload_we;
    logic       irq_disable_we;
    logic       irq_enable_we;
    logic [7:0] cpu_data;
    logic       irq_pending;
    logic [7:0] irq_counter;

    int total = 0;
    int bad   = 0;

    mmc3_scanline_irq dut (
        .m2             (m2),
        .reset          (reset),
        .ppu_a12        (ppu_a12),
        .irq_latch_we   (irq_latch_we),
        .irq_reload_we  (irq_reload_we),
        .irq_disable_we (irq_disable_we),
        .irq_enable_we  (irq_enable_we),
        .cpu_data       (cpu_data),
        .irq_pending    (irq_pending),
        .irq_counter    (irq_counter)
    );

    always #5 m2 = ~m2;

    task automatic tick();
        @(posedge m2);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr_latch(input logic [7:0] d);
        cpu_data = d;
        irq_latch_we = 1'b1;
        tick();
        irq_latch_we = 1'b0;
    endtask

    task automatic do_reload();
        irq_reload_we = 1'b1;
        tick();
        irq_reload_we = 1'b0;
    endtask

    task automatic do_enable();
        irq_enable_we = 1'b1;
        tick();
        irq_enable_we = 1'b0;
    endtask

    task automatic do_disable();
        irq_disable_we = 1'b1;
        tick();
        irq_disable_we = 1'b0;
    endtask

    task automatic pulse(input int lo, input int hi);
        ppu_a12 = 1'b0;
        repeat (lo) tick();
        ppu_a12 = 1'b1;
        repeat (hi) tick();
    endtask

    logic exp_p;

    initial begin
        reset = 1'b1;
        ppu_a12 = 1'b1;
        irq_latch_we = 1'b0;
        irq_reload_we = 1'b0;
        irq_disable_we = 1'b0;
        irq_enable_we = 1'b0;
        cpu_data = 8'd0;
        repeat (3) tick();
        check("reset_counter", 32'(irq_counter), 32'd0);
        check("reset_pending", 32'(irq_pending), 32'd0);
        reset = 1'b0;
        repeat (4) tick();
        check("post_reset_counter", 32'(irq_counter), 32'd0);

        // 1: latch=3 countdown 3,2,1,0 then reload 3
        wr_latch(8'd3);
        do_reload();
        do_enable();
        pulse(4, 4); check("t1_p1_cnt", 32'(irq_counter), 32'd3); check("t1_p1_irq", 32'(irq_pending), 32'd0);
        pulse(4, 4); check("t1_p2_cnt", 32'(irq_counter), 32'd2); check("t1_p2_irq", 32'(irq_pending), 32'd0);
        pulse(4, 4); check("t1_p3_cnt", 32'(irq_counter), 32'd1); check("t1_p3_irq", 32'(irq_pending), 32'd0);
        pulse(4, 4); check("t1_p4_cnt", 32'(irq_counter), 32'd0); check("t1_p4_irq", 32'(irq_pending), 32'd1);
        pulse(4, 4); check("t1_p5_cnt", 32'(irq_counter), 32'd3); check("t1_p5_irq", 32'(irq_pending), 32'd1);
        do_disable();
        check("t1_ack", 32'(irq_pending), 32'd0);

        // 2: short low period is filtered, minimum low period counts
        pulse(2, 4); check("t2_short_low", 32'(irq_counter), 32'd3);
        pulse(3, 4); check("t2_min_low", 32'(irq_counter), 32'd2);

        // 3: latch=0 fires every scanline (default) or once per reload (old rev)
`ifdef MMC3_IRQ_OLD_REV_EN
        exp_p = 1'b0;
`else
        exp_p = 1'b1;
`endif
        wr_latch(8'd0);
        do_reload();
        do_enable();
        pulse(4, 4); check("t3_p1_cnt", 32'(irq_counter), 32'd0); check("t3_p1_irq", 32'(irq_pending), 32'd1);
        do_disable(); do_enable();
        check("t3_ack1", 32'(irq_pending), 32'd0);
        pulse(4, 4); check("t3_p2_irq", 32'(irq_pending), 32'(exp_p));
        do_disable(); do_enable();
        pulse(4, 4); check("t3_p3_irq", 32'(irq_pending), 32'(exp_p)); check("t3_p3_cnt", 32'(irq_counter), 32'd0);

        // 4: disable coincident with the 1->0 clk_evt
        do_disable();
        wr_latch(8'd2);
        do_reload();
        do_enable();
        pulse(4, 4); check("t4_load", 32'(irq_counter), 32'd2);
        pulse(4, 4); check("t4_dec", 32'(irq_counter), 32'd1);
        ppu_a12 = 1'b0;
        repeat (4) tick();
        ppu_a12 = 1'b1;
        repeat (3) tick();
        check("t4_latency", 32'(irq_counter), 32'd1);
        irq_disable_we = 1'b1;
        tick();
        irq_disable_we = 1'b0;
        check("t4_cnt", 32'(irq_counter), 32'd0);
        check("t4_irq", 32'(irq_pending), 32'd0);
        tick();

        // 5: latch write + reload on a clk_evt uses the old latch
        wr_latch(8'd5);
        do_reload();
        pulse(4, 4); check("t5_load5", 32'(irq_counter), 32'd5);
        ppu_a12 = 1'b0;
        repeat (4) tick();
        ppu_a12 = 1'b1;
        repeat (3) tick();
        cpu_data = 8'd9;
        irq_latch_we = 1'b1;
        irq_reload_we = 1'b1;
        tick();
        irq_latch_we = 1'b0;
        irq_reload_we = 1'b0;
        check("t5_old_latch", 32'(irq_counter), 32'd5);
        tick();
        do_reload();
        check("t5_reload_zero", 32'(irq_counter), 32'd0);
        pulse(4, 4); check("t5_new_latch", 32'(irq_counter), 32'd9);

        // 6: asynchronous reset mid-count, then filter restarts
        wr_latch(8'd1);
        do_reload();
        do_enable();
        pulse(4, 4); check("t6_load1", 32'(irq_counter), 32'd1);
        pulse(4, 4); check("t6_zero_irq", 32'(irq_pending), 32'd1);
        wr_latch(8'd2);
        pulse(4, 4);
        check("t6_pre_cnt", 32'(irq_counter), 32'd2);
        check("t6_pre_irq", 32'(irq_pending), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check("t6_async_cnt", 32'(irq_counter), 32'd0);
        check("t6_async_irq", 32'(irq_pending), 32'd0);
        #2;
        reset = 1'b0;
        wr_latch(8'd7);
        repeat (6) tick();
        check("t6_first_rise_ignored", 32'(irq_counter), 32'd0);
        check("t6_irq_after", 32'(irq_pending), 32'd0);
        pulse(3, 4); check("t6_count_resumes", 32'(irq_counter), 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
